pg_seq_ctrl: RTL and testbench
==============================

PG_SEQ_CTRL -- requirements
Module: nvdla_pg_seq_ctrl

Interface
REQ-001 SHALL have parameter DLY_W, default 4, width of isolation/clear step delay config.
REQ-002 SHALL have parameter TO_W, default 8, width of power-switch ack timeout config.
REQ-003 SHALL have port nvdla_core_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port nvdla_core_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port pg_off_req  input  1  level request: 1 = power domain off, 0 = power domain on.
REQ-006 SHALL have port cfg_dly  input  DLY_W  step delay; each timed step lasts cfg_dly+1 cycles.
REQ-007 SHALL have port cfg_to  input  TO_W  ack timeout; switch wait lasts at most cfg_to+1 cycles.
REQ-008 SHALL have port psw_ack  input  1  power-switch status from domain: 1 = powered.
REQ-009 SHALL have port err_clr  input  1  single-cycle clear of pg_err.
REQ-010 SHALL have port iso_en  output  1  domain output isolation enable.
REQ-011 SHALL have port dom_cdn  output  1  active-low clear driven to the CDN pins of the domain flop bank.
REQ-012 SHALL have port psw_en  output  1  power-switch enable, 1 = on.
REQ-013 SHALL have port pg_state  output  3  current state encoding.
REQ-014 SHALL have port pg_done  output  1  one-cycle pulse on sequence completion.
REQ-015 SHALL have port pg_err  output  1  sticky switch-ack timeout flag.

Function
REQ-016 SHALL implement states ON=0, ISO=1, CLR=2, PDN=3, OFF=4, PUP=5, REL=6, DEISO=7, encoded on pg_state.
REQ-017 SHALL drive outputs (iso_en,dom_cdn,psw_en) as registered functions of state: ON 0,1,1; ISO 1,1,1; CLR 1,0,1; PDN 1,0,0; OFF 1,0,0; PUP 1,0,1; REL 1,1,1; DEISO 0,1,1.
REQ-018 SHALL transition ON->ISO when pg_off_req=1, and OFF->PUP when pg_off_req=0; otherwise hold.
REQ-019 SHALL load a step counter with cfg_dly on entry to ISO, CLR, REL; decrement each cycle; advance ISO->CLR, CLR->PDN, REL->DEISO in the cycle after the counter reads 0.
REQ-020 SHALL sample cfg_dly and cfg_to only at state entry; changes mid-state have no effect.
REQ-021 SHALL load a timeout counter with cfg_to on entry to PDN and PUP.
REQ-022 SHALL advance PDN->OFF when psw_ack=0, PUP->REL when psw_ack=1, evaluated every cycle in the state including the first.
REQ-023 SHALL, if the ack condition is unmet when the timeout counter reads 0, set pg_err and advance as if ack were met.
REQ-024 SHALL advance DEISO->ON unconditionally after one cycle.
REQ-025 SHALL ignore pg_off_req changes in ISO, CLR, PDN, PUP, REL, DEISO; no abort; a reversed request is serviced once ON or OFF is reached.
REQ-026 SHALL assert pg_done for exactly the first cycle in ON or OFF following a completed sequence; never after reset alone.
REQ-027 SHALL clear pg_err on err_clr=1; a simultaneous new timeout SHALL take priority (pg_err stays 1).
REQ-028 SHALL guarantee dom_cdn is never 1 while psw_en is 0, and iso_en is 1 whenever dom_cdn is 0 or psw_en is 0.

Reset
REQ-029 SHALL, with nvdla_core_rst=1 at a clock edge, enter OFF: iso_en=1, dom_cdn=0, psw_en=0, pg_state=4, pg_done=0, pg_err=0, counters 0.
REQ-030 SHALL apply reset mid-sequence identically, abandoning any step or timeout in progress.

Verification
REQ-031 Reset release, pg_off_req=0, cfg_dly=2, psw_ack=1 -> PUP 1 cycle, REL 3 cycles, DEISO 1 cycle, ON with pg_done pulse; pg_done first high 6 cycles after first post-reset edge.
REQ-032 From ON, pg_off_req=1, cfg_dly=0, psw_ack falls 2 cycles after psw_en=0 -> ISO 1, CLR 1, PDN 3 cycles, OFF with pg_done; pg_err=0.
REQ-033 PUP with cfg_to=3, psw_ack held 0 -> 4 cycles in PUP, pg_err=1, enter REL; err_clr pulse -> pg_err=0 next cycle.
REQ-034 pg_off_req toggled 1->0 during CLR -> sequence completes to OFF with pg_done, then PUP entered the following cycle.
REQ-035 Reset asserted in REL -> next cycle OFF with outputs 1,0,0, pg_err=0; REQ-028 checked by assertion across all scenarios.

Source files
------------

// File: rtl/pg_seq_ctrl.sv
// Power-gating sequencer: walks a power domain through isolate/clear/switch-off
// and switch-on/release/de-isolate, with per-step delays and a switch-ack timeout.
module pg_seq_ctrl #(
  parameter int DLY_W = 4,
  parameter int TO_W  = 8
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             pg_off_req,
  input  logic [DLY_W-1:0] cfg_dly,
  input  logic [TO_W-1:0]  cfg_to,
  input  logic             psw_ack,
  input  logic             err_clr,
  output logic             iso_en,
  output logic             dom_cdn,
  output logic             psw_en,
  output logic [2:0]       pg_state,
  output logic             pg_done,
  output logic             pg_err
);

  typedef enum logic [2:0] {
    ST_ON    = 3'd0,
    ST_ISO   = 3'd1,
    ST_CLR   = 3'd2,
    ST_PDN   = 3'd3,
    ST_OFF   = 3'd4,
    ST_PUP   = 3'd5,
    ST_REL   = 3'd6,
    ST_DEISO = 3'd7
  } state_t;

  localparam logic [DLY_W-1:0] STEP_ONE = DLY_W'(1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  state_t           state_reg, state_next;
  logic [DLY_W-1:0] step_reg, step_next;
  logic [TO_W-1:0]  to_reg, to_next;
  logic             err_set;
  logic             done_next;
  logic [2:0]       out_next;

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    to_next    = to_reg;
    err_set    = 1'b0;
    case (state_reg)
      ST_ON: if (pg_off_req) begin
        state_next = ST_ISO;
        step_next  = cfg_dly;
      end
      ST_ISO: if (step_reg == '0) begin
        state_next = ST_CLR;
        step_next  = cfg_dly;
      end else step_next = step_reg - STEP_ONE;
      ST_CLR: if (step_reg == '0) begin
        state_next = ST_PDN;
        to_next    = cfg_to;
      end else step_next = step_reg - STEP_ONE;
      // A missing ack never stalls the sequence: on timeout we flag and move on.
      ST_PDN: if (!psw_ack) begin
        state_next = ST_OFF;
      end else if (to_reg == '0) begin
        state_next = ST_OFF;
        err_set    = 1'b1;
      end else to_next = to_reg - TO_ONE;
      ST_OFF: if (!pg_off_req) begin
        state_next = ST_PUP;
        to_next    = cfg_to;
      end
      ST_PUP: if (psw_ack || to_reg == '0) begin
        state_next = ST_REL;
        step_next  = cfg_dly;
        err_set    = !psw_ack;
      end else to_next = to_reg - TO_ONE;
      ST_REL: if (step_reg == '0) state_next = ST_DEISO;
              else step_next = step_reg - STEP_ONE;
      ST_DEISO: state_next = ST_ON;
      default:  state_next = ST_OFF;
    endcase

    done_next = (state_reg == ST_PDN   && state_next == ST_OFF) ||
                (state_reg == ST_DEISO && state_next == ST_ON);

    // {iso_en, dom_cdn, psw_en} for the state being entered
    case (state_next)
      ST_ON:    out_next = 3'b011;
      ST_ISO:   out_next = 3'b111;
      ST_CLR:   out_next = 3'b101;
      ST_PDN:   out_next = 3'b100;
      ST_OFF:   out_next = 3'b100;
      ST_PUP:   out_next = 3'b101;
      ST_REL:   out_next = 3'b111;
      ST_DEISO: out_next = 3'b011;
      default:  out_next = 3'b100;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_reg <= ST_OFF;
      step_reg  <= '0;
      to_reg    <= '0;
      iso_en    <= 1'b1;
      dom_cdn   <= 1'b0;
      psw_en    <= 1'b0;
      pg_done   <= 1'b0;
      pg_err    <= 1'b0;
    end else begin
      state_reg                  <= state_next;
      step_reg                   <= step_next;
      to_reg                     <= to_next;
      {iso_en, dom_cdn, psw_en}  <= out_next;
      pg_done                    <= done_next;
      if (err_set)      pg_err <= 1'b1;
      else if (err_clr) pg_err <= 1'b0;
    end
  end

  assign pg_state = state_reg;

endmodule

// File: tb/tb_pg_seq_ctrl.sv
// Directed bench for pg_seq_ctrl: a cycle model built from the phase rules is
// checked every cycle, plus literal expectations for the key scenarios.
module tb_pg_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, off_req, ack, clr;
  logic [3:0] dly;
  logic [7:0] tmo;
  logic       iso_en, dom_cdn, psw_en, pg_done, pg_err;
  logic [2:0] pg_state;

  int checks = 0;
  int errors = 0;

  pg_seq_ctrl #(.DLY_W(4), .TO_W(8)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .pg_off_req(off_req),
    .cfg_dly(dly), .cfg_to(tmo), .psw_ack(ack), .err_clr(clr),
    .iso_en(iso_en), .dom_cdn(dom_cdn), .psw_en(psw_en),
    .pg_state(pg_state), .pg_done(pg_done), .pg_err(pg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Phase model: each phase has a remaining-cycle budget; outputs from a table.
  int  m_phase, m_left, m_valid = 0;
  bit  m_done, m_err;

  function automatic logic [2:0] phase_out(input int p);
    logic [2:0] o;
    case (p)
      0: o = 3'b011; 1: o = 3'b111; 2: o = 3'b101; 3: o = 3'b100;
      4: o = 3'b100; 5: o = 3'b101; 6: o = 3'b111; default: o = 3'b011;
    endcase
    return o;
  endfunction

  always @(posedge clk) begin
    int nxt;
    bit tmo_hit;
    if (rst) begin
      m_phase = 4; m_left = 0; m_done = 0; m_err = 0; m_valid = 1;
    end else if (m_valid != 0) begin
      nxt = m_phase; tmo_hit = 0;
      if (m_phase == 0 && off_req) nxt = 1;
      else if (m_phase == 4 && !off_req) nxt = 5;
      else if (m_phase == 7) nxt = 0;
      else if (m_phase == 3 || m_phase == 5) begin
        if ((m_phase == 3) ? !ack : ack) nxt = m_phase + 1;
        else if (m_left == 0) begin nxt = m_phase + 1; tmo_hit = 1; end
      end else if (m_phase == 1 || m_phase == 2 || m_phase == 6) begin
        if (m_left == 0) nxt = m_phase + 1;
      end
      if (nxt != m_phase) begin
        if (nxt == 1 || nxt == 2 || nxt == 6) m_left = int'(dly);
        else if (nxt == 3 || nxt == 5)        m_left = int'(tmo);
      end else if (m_left > 0) m_left--;
      m_done  = (m_phase == 3 && nxt == 4) || (m_phase == 7 && nxt == 0);
      m_err   = tmo_hit ? 1'b1 : (clr ? 1'b0 : m_err);
      m_phase = nxt;
    end
  end

  always @(negedge clk) begin
    logic [2:0] o;
    if (m_valid != 0) begin
      o = phase_out(m_phase);
      chk("m_state", int'(pg_state), m_phase);
      chk("m_iso",   int'(iso_en),  int'(o[2]));
      chk("m_cdn",   int'(dom_cdn), int'(o[1]));
      chk("m_psw",   int'(psw_en),  int'(o[0]));
      chk("m_done",  int'(pg_done), int'(m_done));
      chk("m_err",   int'(pg_err),  int'(m_err));
      chk("cdn_without_psw", int'(dom_cdn && !psw_en), 0);
      chk("iso_missing", int'((!dom_cdn || !psw_en) && !iso_en), 0);
    end
  end

  int cyc [8];
  int arr_done;

  // Observe until target state is seen; optionally drop psw_ack once psw_en
  // has been seen low on drop_at observations.
  task automatic run_to(input int target, input int drop_at, input string name);
    int psw0 = 0;
    bit hit = 0;
    for (int k = 0; k < 8; k++) cyc[k] = 0;
    arr_done = -1;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (!psw_en) psw0++;
      if (drop_at > 0 && psw0 == drop_at) ack = 1'b0;
      if (int'(pg_state) == target) begin
        hit = 1; arr_done = int'(pg_done);
      end else cyc[pg_state]++;
    end
    chk({name, "_reached"}, int'(hit), 1);
  endtask

  int exp_st [7] = '{5, 6, 6, 6, 7, 0, 0};
  int exp_dn [7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    rst = 1; off_req = 0; ack = 1; clr = 0; dly = 4'd2; tmo = 8'd8;
    repeat (2) @(negedge clk);
    chk("rst_state", int'(pg_state), 4);
    chk("rst_outs", int'({iso_en, dom_cdn, psw_en}), 3'b100);
    chk("rst_done_err", int'({pg_done, pg_err}), 0);
    rst = 0;

    // power-up after reset
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("pup_state%0d", i), int'(pg_state), exp_st[i]);
      chk($sformatf("pup_done%0d", i), int'(pg_done), exp_dn[i]);
    end
    $display("txn power-up after reset: state=%0d", pg_state);

    // power-down, ack falls two cycles after switch-off
    dly = 4'd0; off_req = 1;
    run_to(4, 3, "pdn");
    chk("pdn_iso_cycles", cyc[1], 1);
    chk("pdn_clr_cycles", cyc[2], 1);
    chk("pdn_pdn_cycles", cyc[3], 3);
    chk("pdn_done", arr_done, 1);
    chk("pdn_err", int'(pg_err), 0);
    $display("txn power-down: pdn cycles=%0d done=%0d", cyc[3], arr_done);

    // power-up with ack timeout, then clear
    off_req = 0; tmo = 8'd3; dly = 4'd1;
    run_to(6, 0, "tmo");
    chk("tmo_pup_cycles", cyc[5], 4);
    chk("tmo_err_set", int'(pg_err), 1);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("tmo_err_cleared", int'(pg_err), 0);
    ack = 1;
    run_to(0, 0, "tmo_on");
    chk("tmo_on_done", arr_done, 1);
    $display("txn timeout power-up: err set and cleared");

    // request reversed during CLR
    dly = 4'd2; tmo = 8'd5; ack = 0; off_req = 1;
    run_to(2, 0, "rev_clr");
    off_req = 0;
    run_to(4, 0, "rev_off");
    chk("rev_done", arr_done, 1);
    @(negedge clk);
    chk("rev_pup_next", int'(pg_state), 5);
    ack = 1;
    run_to(0, 0, "rev_on");
    $display("txn reversed request: serviced after OFF");

    // power-down timeout with err_clr held: timeout wins
    dly = 4'd0; tmo = 8'd1; ack = 1; off_req = 1;
    run_to(3, 0, "prio_pdn");
    clr = 1;
    run_to(4, 0, "prio_off");
    chk("prio_pdn_cycles", cyc[3], 1);
    chk("prio_err", int'(pg_err), 1);
    clr = 0;
    $display("txn timeout vs clear: err=%0d", pg_err);

    // reset in REL
    off_req = 0; dly = 4'd3;
    run_to(6, 0, "rst_rel");
    rst = 1;
    @(negedge clk);
    chk("mid_rst_state", int'(pg_state), 4);
    chk("mid_rst_outs", int'({iso_en, dom_cdn, psw_en}), 3'b100);
    chk("mid_rst_err", int'(pg_err), 0);
    chk("mid_rst_done", int'(pg_done), 0);
    rst = 0;
    run_to(0, 0, "rst_recover");
    chk("recover_done", arr_done, 1);
    $display("txn reset in REL: recovered to ON");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
